// File: rtl/buffer.sv
// ============================================================================
// Module   : buffer
// Brief    : Dual-port 80x30 tile buffer for the VGA text controller,
//            one write and one read-first registered read per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module buffer #(
    parameter int COLS   = 80,
    parameter int ROWS   = 30,
    parameter int DATA_W = 7,
    parameter int COL_W  = 7,
    parameter int ROW_W  = 5
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              wr_en_i,
    input  logic [COL_W-1:0]  col_w_i,
    input  logic [ROW_W-1:0]  row_w_i,
    input  logic [COL_W-1:0]  col_r_i,
    input  logic [ROW_W-1:0]  row_r_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o
);

    localparam int DEPTH = COLS * ROWS;
    localparam int IDX_W = ($clog2(DEPTH) < 12) ? 12 : $clog2(DEPTH);
    localparam logic [COL_W-1:0] COL_LIM = COL_W'(COLS);
    localparam logic [ROW_W-1:0] ROW_LIM = ROW_W'(ROWS);

    // Initial contents are part of the RAM configuration; reset never clears them.
    logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: '0};

    logic             wr_ok;
    logic             rd_ok;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    assign wr_ok  = wr_en_i && (col_w_i < COL_LIM) && (row_w_i < ROW_LIM);
    assign rd_ok  = (col_r_i < COL_LIM) && (row_r_i < ROW_LIM);
    assign wr_idx = IDX_W'(row_w_i) * IDX_W'(COLS) + IDX_W'(col_w_i);
    assign rd_idx = IDX_W'(row_r_i) * IDX_W'(COLS) + IDX_W'(col_r_i);

    always_ff @(posedge clk_i) begin
        if (rstn_i && wr_ok) begin
            mem[wr_idx] <= din_i;
        end
    end

    // Non-blocking update of mem gives read-first behaviour on address collision.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dout_o <= '0;
        end else if (rd_ok) begin
            dout_o <= mem[rd_idx];
        end else begin
            dout_o <= '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_buffer.sv
// ============================================================================
// Module   : tb_buffer
// Brief    : Self-checking bench for the buffer tile RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_buffer;

    logic       clk;
    logic       rstn;
    logic       wr_en;
    logic [6:0] col_w;
    logic [4:0] row_w;
    logic [6:0] col_r;
    logic [4:0] row_r;
    logic [6:0] din;
    logic [6:0] dout;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string      nm;
        logic [6:0] val;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        string      nm;
        logic       we;
        logic [6:0] cw;
        logic [4:0] rw;
        logic [6:0] cr;
        logic [4:0] rr;
        logic [6:0] d;
        logic [6:0] ex;
    } vec_t;

    vec_t vecs[$];

    buffer dut (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .wr_en_i (wr_en),
        .col_w_i (col_w),
        .row_w_i (row_w),
        .col_r_i (col_r),
        .row_r_i (row_r),
        .din_i   (din),
        .dout_o  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_now(input string nm, input logic [6:0] ex);
        n_vec++;
        if (dout !== ex) begin
            n_err++;
            $display("FAIL %s: dout=%0d expected=%0d at %0t", nm, dout, ex, $time);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected read, then compare after the edge.
    task automatic apply(input string nm, input logic we, input logic [6:0] cw,
                         input logic [4:0] rw, input logic [6:0] cr,
                         input logic [4:0] rr, input logic [6:0] d,
                         input logic [6:0] ex);
        exp_t e;
        wr_en = we; col_w = cw; row_w = rw; col_r = cr; row_r = rr; din = d;
        e.nm  = nm;
        e.val = ex;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard: queue empty");
        end else begin
            e = sb.pop_front();
            check_now(e.nm, e.val);
        end
    endtask

    task automatic add(input string nm, input logic we, input int cw, input int rw,
                       input int cr, input int rr, input int d, input int ex);
        vec_t v;
        v.nm = nm; v.we = we;
        v.cw = 7'(cw); v.rw = 5'(rw); v.cr = 7'(cr); v.rr = 5'(rr);
        v.d  = 7'(d);  v.ex = 7'(ex);
        vecs.push_back(v);
    endtask

    initial begin
        rstn = 1'b0; wr_en = 1'b0; col_w = '0; row_w = '0;
        col_r = '0;  row_r = '0;   din = '0;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_state", 7'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Initial read scan: everything configured to zero.
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                apply("init_scan", 1'b0, 7'd0, 5'd0, 7'(c), 5'(r), 7'd0, 7'd0);

        // Lockstep fill: read-first means every read still sees zero.
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                apply("fill_scan", 1'b1, 7'(c), 5'(r), 7'(c), 5'(r),
                      7'((r * 80 + c) % 128), 7'd0);
        wr_en = 1'b0;

        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                apply("readback", 1'b0, 7'd0, 5'd0, 7'(c), 5'(r), 7'd0,
                      7'((r * 80 + c) % 128));

        // (name, we, cw, rw, cr, rr, din, expected dout)
        add("wr_disabled",    1'b0,   5,  3,   5,  3, 'h55, 117);
        add("wr_disabled_rb", 1'b0,   0,  0,   5,  3,    0, 117);
        add("oor_wr_col",     1'b1,  80,  0,   0,  1, 'h7f,  80);
        add("oor_wr_col_rb",  1'b0,   0,  0,   0,  1,    0,  80);
        add("oor_wr_row",     1'b1,   0, 30,  79, 29, 'h7f,  95);
        add("oor_wr_row_rb",  1'b0,   0,  0,   0,  0,    0,   0);
        add("oor_rd_100_31",  1'b0,   0,  0, 100, 31,    0,   0);
        add("oor_rd_127_0",   1'b0,   0,  0, 127,  0,    0,   0);
        add("oor_rd_80_0",    1'b0,   0,  0,  80,  0,    0,   0);
        add("oor_rd_0_30",    1'b0,   0,  0,   0, 30,    0,   0);
        add("rdw_old",        1'b1,  10,  2,  10,  2, 'h11,  42);
        add("rdw_new",        1'b0,   0,  0,  10,  2,    0, 'h11);
        add("indep_wr",       1'b1,  79, 29,   0,  0,    1,   0);
        add("indep_rb",       1'b0,   0,  0,  79, 29,    0,   1);
        add("indep_rb_nb",    1'b0,   0,  0,  78, 29,    0,  94);
        foreach (vecs[i])
            apply(vecs[i].nm, vecs[i].we, vecs[i].cw, vecs[i].rw,
                  vecs[i].cr, vecs[i].rr, vecs[i].d, vecs[i].ex);

        // Mid-scan asynchronous reset.
        for (int c = 0; c < 6; c++)
            apply("pre_reset_scan", 1'b0, 7'd0, 5'd0, 7'(c), 5'd0, 7'd0, 7'(c));
        #2;
        rstn = 1'b0;
        #1;
        check_now("async_reset", 7'd0);
        wr_en = 1'b1; col_w = 7'd2; row_w = 5'd0; din = 7'h7e;
        col_r = 7'd3; row_r = 5'd0;
        @(posedge clk);
        #1;
        check_now("reset_hold", 7'd0);
        wr_en = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        col_r = 7'd1; row_r = 5'd0;
        #1;
        check_now("reset_released", 7'd0);
        @(posedge clk);
        #1;
        check_now("post_reset_rd", 7'd1);
        apply("wr_blocked_in_reset", 1'b0, 7'd0, 5'd0, 7'd2, 5'd0, 7'd0, 7'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
